// File: rtl/rising_edge_detect_pkg.sv
// Shared constants for the rising-edge detector slice.
package rising_edge_detect_pkg;

    localparam int unsigned DEFAULT_WIDTH   = 1;
    localparam int unsigned MAX_SYNC_STAGES = 4;

    // Out-of-range stage counts saturate rather than breaking elaboration.
    function automatic int unsigned clamp_sync_stages(input int unsigned stages);
        return (stages > MAX_SYNC_STAGES) ? MAX_SYNC_STAGES : stages;
    endfunction

endpackage

// File: rtl/rising_edge_detect_if.sv
// Level-in / strobe-out bundle between a monitored source and the edge detector.
interface rising_edge_detect_if
    import rising_edge_detect_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] pulse;
    logic [WIDTH-1:0] fall;

    modport master (output din, input pulse, input fall);
    modport slave  (input din, output pulse, output fall);
endinterface

// File: rtl/rising_edge_detect_sync.sv
// Per-bit N-stage flop synchronizer with async active-high reset; N=0 is a wire.
module rising_edge_detect_sync
    import rising_edge_detect_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STAGES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat
);

    generate
        if (STAGES == 0) begin : g_bypass
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk ^ rst;
            assign o_dat = i_dat;
        end else begin : g_sync
            logic [WIDTH-1:0] r_stage [STAGES];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < int'(STAGES); i++) r_stage[i] <= '0;
                end else begin
                    r_stage[0] <= i_dat;
                    for (int i = 1; i < int'(STAGES); i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_dat = r_stage[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/rising_edge_detect.sv
// Per-lane 0->1 (and optionally 1->0) detector producing registered one-cycle strobes.
module rising_edge_detect
    import rising_edge_detect_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_WIDTH,
    parameter int unsigned SYNC_STAGES = 0,
    parameter bit          DETECT_FALL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rstn,
    rising_edge_detect_if.slave   bus
);

    localparam int unsigned N_SYNC = clamp_sync_stages(SYNC_STAGES);

    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_pulse_nxt;
    logic [WIDTH-1:0] w_fall_nxt;
    logic [WIDTH-1:0] r_din_prev;
    logic [WIDTH-1:0] r_pulse;
    logic [WIDTH-1:0] r_fall;

    rising_edge_detect_sync #(
        .WIDTH  (WIDTH),
        .STAGES (N_SYNC)
    ) u_sync (
        .clk   (clk),
        .rst   (rstn),
        .i_dat (bus.din),
        .o_dat (w_s)
    );

    // History clears to 0 in reset, so a level already high at release counts as an edge.
    assign w_pulse_nxt = w_s & ~r_din_prev;
    assign w_fall_nxt  = DETECT_FALL ? (~w_s & r_din_prev) : '0;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_din_prev <= '0;
            r_pulse    <= '0;
            r_fall     <= '0;
        end else begin
            r_din_prev <= w_s;
            r_pulse    <= w_pulse_nxt;
            r_fall     <= w_fall_nxt;
        end
    end

    assign bus.pulse = r_pulse;
    assign bus.fall  = r_fall;

endmodule

// File: tb/tb_rising_edge_detect.sv
// Directed bench: three detector configurations sharing one clock and reset.
module tb_rising_edge_detect;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rising_edge_detect_if #(.WIDTH(1)) if_a ();
    rising_edge_detect_if #(.WIDTH(1)) if_s ();
    rising_edge_detect_if #(.WIDTH(4)) if_w ();

    rising_edge_detect #(.WIDTH(1), .SYNC_STAGES(0), .DETECT_FALL(1'b1)) dut_a (
        .clk (clk), .rstn (rstn), .bus (if_a)
    );
    rising_edge_detect #(.WIDTH(1), .SYNC_STAGES(2), .DETECT_FALL(1'b0)) dut_s (
        .clk (clk), .rstn (rstn), .bus (if_s)
    );
    rising_edge_detect #(.WIDTH(4), .SYNC_STAGES(0), .DETECT_FALL(1'b1)) dut_w (
        .clk (clk), .rstn (rstn), .bus (if_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        if_a.din = 1'b0;
        if_s.din = 1'b0;
        if_w.din = 4'b0000;
        rstn     = 1'b1;
        tick();
        tick();
        checks++; if (if_a.pulse !== 1'b0) begin errors++; $display("FAIL reset_a_pulse got=%b want=0", if_a.pulse); end
        checks++; if (if_a.fall  !== 1'b0) begin errors++; $display("FAIL reset_a_fall got=%b want=0", if_a.fall); end
        checks++; if (if_s.pulse !== 1'b0) begin errors++; $display("FAIL reset_s_pulse got=%b want=0", if_s.pulse); end
        checks++; if (if_w.pulse !== 4'b0000) begin errors++; $display("FAIL reset_w_pulse got=%b want=0000", if_w.pulse); end
        checks++; if (if_w.fall  !== 4'b0000) begin errors++; $display("FAIL reset_w_fall got=%b want=0000", if_w.fall); end
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (if_a.pulse !== 1'b0 || if_a.fall !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got pulse=%b fall=%b want 0/0", i, if_a.pulse, if_a.fall);
            end
        end
    endtask

    task automatic test_basic_edge();
        logic din_seq [13] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
        logic exp_p   [13] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0};
        logic exp_f   [13] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};
        int   n_pulse = 0;
        for (int i = 0; i < 13; i++) begin
            if_a.din = din_seq[i];
            tick();
            if (if_a.pulse === 1'b1) n_pulse++;
            checks++;
            if (if_a.pulse !== exp_p[i]) begin
                errors++;
                $display("FAIL basic_pulse cyc=%0d got=%b want=%b", i, if_a.pulse, exp_p[i]);
            end
            checks++;
            if (if_a.fall !== exp_f[i]) begin
                errors++;
                $display("FAIL basic_fall cyc=%0d got=%b want=%b", i, if_a.fall, exp_f[i]);
            end
        end
        checks++;
        if (n_pulse != 2) begin errors++; $display("FAIL basic_count got=%0d want=2", n_pulse); end
    endtask

    task automatic test_power_up_high();
        rstn     = 1'b1;
        if_a.din = 1'b1;
        tick();
        checks++; if (if_a.pulse !== 1'b0) begin errors++; $display("FAIL pwr_in_reset got=%b want=0", if_a.pulse); end
        rstn = 1'b0;
        tick();
        checks++; if (if_a.pulse !== 1'b1) begin errors++; $display("FAIL pwr_first got=%b want=1", if_a.pulse); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (if_a.pulse !== 1'b0 || if_a.fall !== 1'b0) begin
                errors++;
                $display("FAIL pwr_hold cyc=%0d got pulse=%b fall=%b want 0/0", i, if_a.pulse, if_a.fall);
            end
        end
    endtask

    task automatic test_async_reset_mid_pulse();
        if_a.din = 1'b0;
        tick();
        if_a.din = 1'b1;
        tick();
        checks++; if (if_a.pulse !== 1'b1) begin errors++; $display("FAIL arst_pre got=%b want=1", if_a.pulse); end
        #2;
        rstn = 1'b1;
        #1;
        checks++; if (if_a.pulse !== 1'b0) begin errors++; $display("FAIL arst_async got=%b want=0", if_a.pulse); end
        if_a.din = 1'b0;
        tick();
        rstn = 1'b0;
        tick();
        checks++; if (if_a.pulse !== 1'b0) begin errors++; $display("FAIL arst_no_reemit got=%b want=0", if_a.pulse); end
        if_a.din = 1'b1;
        tick();
        checks++; if (if_a.pulse !== 1'b1) begin errors++; $display("FAIL arst_resume got=%b want=1", if_a.pulse); end
        if_a.din = 1'b0;
        tick();
    endtask

    task automatic test_sync_blip();
        logic exp_p [6] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
        for (int i = 0; i < 6; i++) begin
            if_s.din = (i == 0) ? 1'b1 : 1'b0;
            tick();
            checks++;
            if (if_s.pulse !== exp_p[i] || if_s.fall !== 1'b0) begin
                errors++;
                $display("FAIL blip cyc=%0d got pulse=%b fall=%b want %b/0", i, if_s.pulse, if_s.fall, exp_p[i]);
            end
        end
    endtask

    task automatic test_lanes();
        logic [3:0] din_seq [6] = '{4'b0000, 4'b0101, 4'b1111, 4'b1111, 4'b0000, 4'b0000};
        logic [3:0] exp_p   [6] = '{4'b0000, 4'b0101, 4'b1010, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0] exp_f   [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            if_w.din = din_seq[i];
            tick();
            checks++;
            if (if_w.pulse !== exp_p[i] || if_w.fall !== exp_f[i]) begin
                errors++;
                $display("FAIL lanes cyc=%0d got pulse=%b fall=%b want %b/%b",
                         i, if_w.pulse, if_w.fall, exp_p[i], exp_f[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic din_seq [5] = '{1'b1,1'b0,1'b1,1'b0,1'b0};
        logic exp_p   [5] = '{1'b1,1'b0,1'b1,1'b0,1'b0};
        logic exp_f   [5] = '{1'b0,1'b1,1'b0,1'b1,1'b0};
        for (int i = 0; i < 5; i++) begin
            if_a.din = din_seq[i];
            tick();
            checks++;
            if (if_a.pulse !== exp_p[i] || if_a.fall !== exp_f[i]) begin
                errors++;
                $display("FAIL b2b cyc=%0d got pulse=%b fall=%b want %b/%b",
                         i, if_a.pulse, if_a.fall, exp_p[i], exp_f[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_edge();
        test_power_up_high();
        test_async_reset_mid_pulse();
        test_sync_blip();
        test_lanes();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
